// File: rtl/pulse_sequencer.sv
// Sequences a table of pattern/repeat slots into a 16-bit rotating pulse generator.
// Latency: START -> LOAD strobe visible 1 cycle later; each slot lasts 16*R cycles from its LOAD edge.
// Backpressure: none; START is ignored while busy, ABORT returns to IDLE at the next edge.
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   CFG_WE/ADDR/PATTERN/REPEAT   slot table write port (accepted in any state)
//   NUM_SLOTS, LOOP     slots to play (latched at START), wrap-around enable (sampled at wrap)
//   START, ABORT        sequence control; ABORT wins
//   GEN_LOAD, GEN_VALUE load strobe and load word for the generator
//   SLOT_IDX, BUSY, DONE  status (all registered)
module pulse_sequencer #(
   parameter int WIDTH = 16,
   parameter int SLOTS = 4,
   parameter int REP_W = 4
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic                       CFG_WE,
   input  logic [$clog2(SLOTS)-1:0]   CFG_ADDR,
   input  logic [WIDTH-1:0]           CFG_PATTERN,
   input  logic [REP_W-1:0]           CFG_REPEAT,
   input  logic [$clog2(SLOTS):0]     NUM_SLOTS,
   input  logic                       LOOP,
   input  logic                       START,
   input  logic                       ABORT,
   output logic                       GEN_LOAD,
   output logic [WIDTH-1:0]           GEN_VALUE,
   output logic [$clog2(SLOTS)-1:0]   SLOT_IDX,
   output logic                       BUSY,
   output logic                       DONE
);

   localparam int AW = $clog2(SLOTS);
   localparam int BW = $clog2(WIDTH);
   localparam logic [AW:0]   SLOTS_W  = (AW+1)'(SLOTS);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Slot table
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] pat_q [SLOTS];
   logic [REP_W-1:0] rep_q [SLOTS];

   // Reads are combinational from the registers, so a write on the same
   // edge as a slot load delivers the pre-edge (old) contents.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < SLOTS; i++) begin
            pat_q[i] <= '0;
            rep_q[i] <= REP_W'(1);
         end
      end else if (CFG_WE) begin
         pat_q[CFG_ADDR] <= CFG_PATTERN;
         rep_q[CFG_ADDR] <= CFG_REPEAT;
      end
   end

   // A programmed repeat of 0 behaves as 1.
   function automatic logic [REP_W-1:0] norm_rep(input logic [REP_W-1:0] r);
      return (r == '0) ? REP_W'(1) : r;
   endfunction

   // ------------------------------------------------------------------
   // Slot count normalisation: 0 -> 1, above SLOTS -> SLOTS. Stored as the
   // index of the last slot to play.
   // ------------------------------------------------------------------
   logic [AW:0]   ns_m1;
   logic [AW-1:0] last_norm;

   always_comb begin
      ns_m1     = NUM_SLOTS - (AW+1)'(1);
      last_norm = ns_m1[AW-1:0];
      if (NUM_SLOTS == '0) begin
         last_norm = '0;
      end else if (NUM_SLOTS > SLOTS_W) begin
         last_norm = AW'(SLOTS - 1);
      end
   end

   // ------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------
   state_t           state_q,     state_d;
   logic             gen_load_q,  gen_load_d;
   logic [WIDTH-1:0] gen_value_q, gen_value_d;
   logic [AW-1:0]    slot_idx_q,  slot_idx_d;
   logic             busy_q,      busy_d;
   logic             done_q,      done_d;
   logic [BW-1:0]    bit_cnt_q,   bit_cnt_d;
   logic [REP_W-1:0] rep_cnt_q,   rep_cnt_d;
   logic [REP_W-1:0] rep_lim_q,   rep_lim_d;
   logic [AW-1:0]    last_q,      last_d;

   logic             enter_slot;
   logic [AW-1:0]    sel_slot;
   logic             go_idle;
   logic             slot_end;

   // The slot's final RUN cycle: last bit of the period in the last repeat.
   // rep_cnt starts at 1 on the LOAD edge and bumps on every 15->0 wrap.
   assign slot_end = (bit_cnt_q == BIT_LAST) && (rep_cnt_q == rep_lim_q);

   always_comb begin
      state_d     = state_q;
      gen_load_d  = gen_load_q;
      gen_value_d = gen_value_q;
      slot_idx_d  = slot_idx_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      bit_cnt_d   = bit_cnt_q;
      rep_cnt_d   = rep_cnt_q;
      rep_lim_d   = rep_lim_q;
      last_d      = last_q;
      enter_slot  = 1'b0;
      sel_slot    = '0;
      go_idle     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // Keep the generator parked at 0 by reloading zero every cycle.
            gen_load_d  = 1'b1;
            gen_value_d = '0;
            busy_d      = 1'b0;
            if (START) begin
               last_d     = last_norm;
               enter_slot = 1'b1;
               sel_slot   = '0;
            end
         end

         S_LOAD: begin
            state_d    = S_RUN;
            gen_load_d = 1'b0;
            bit_cnt_d  = BW'(1);
            rep_cnt_d  = REP_W'(1);
         end

         S_RUN: begin
            gen_load_d = 1'b0;
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_LAST) begin
               rep_cnt_d = rep_cnt_q + 1'b1;
            end
            if (slot_end) begin
               if (slot_idx_q != last_q) begin
                  enter_slot = 1'b1;
                  sel_slot   = slot_idx_q + 1'b1;
               end else if (LOOP) begin
                  enter_slot = 1'b1;
                  sel_slot   = '0;
               end else begin
                  go_idle = 1'b1;
                  done_d  = 1'b1;
               end
            end
         end

         default: begin
            go_idle = 1'b1;
         end
      endcase

      if (enter_slot) begin
         state_d     = S_LOAD;
         slot_idx_d  = sel_slot;
         gen_load_d  = 1'b1;
         gen_value_d = pat_q[sel_slot];
         busy_d      = 1'b1;
         rep_lim_d   = norm_rep(rep_q[sel_slot]);
         bit_cnt_d   = '0;
         rep_cnt_d   = '0;
      end

      // ABORT overrides everything, including a START or a normal finish.
      if (ABORT) begin
         go_idle = 1'b1;
         done_d  = 1'b0;
      end

      if (go_idle) begin
         state_d     = S_IDLE;
         slot_idx_d  = '0;
         gen_load_d  = 1'b1;
         gen_value_d = '0;
         busy_d      = 1'b0;
         bit_cnt_d   = '0;
         rep_cnt_d   = '0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= S_IDLE;
         gen_load_q  <= 1'b1;
         gen_value_q <= '0;
         slot_idx_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         bit_cnt_q   <= '0;
         rep_cnt_q   <= '0;
         rep_lim_q   <= REP_W'(1);
         last_q      <= '0;
      end else begin
         state_q     <= state_d;
         gen_load_q  <= gen_load_d;
         gen_value_q <= gen_value_d;
         slot_idx_q  <= slot_idx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         bit_cnt_q   <= bit_cnt_d;
         rep_cnt_q   <= rep_cnt_d;
         rep_lim_q   <= rep_lim_d;
         last_q      <= last_d;
      end
   end

   assign GEN_LOAD  = gen_load_q;
   assign GEN_VALUE = gen_value_q;
   assign SLOT_IDX  = slot_idx_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer with a behavioural model of the rotating generator.
// Latency: expectations are hand-computed cycle offsets from each START edge.
// Backpressure: not applicable; all waits are fixed-length cycle loops.
module tb_pulse_sequencer;

   logic        CLK;
   logic        RST_N;
   logic        CFG_WE;
   logic [1:0]  CFG_ADDR;
   logic [15:0] CFG_PATTERN;
   logic [3:0]  CFG_REPEAT;
   logic [2:0]  NUM_SLOTS;
   logic        LOOP;
   logic        START;
   logic        ABORT;
   logic        GEN_LOAD;
   logic [15:0] GEN_VALUE;
   logic [1:0]  SLOT_IDX;
   logic        BUSY;
   logic        DONE;

   pulse_sequencer #(.WIDTH(16), .SLOTS(4), .REP_W(4)) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .CFG_WE      (CFG_WE),
      .CFG_ADDR    (CFG_ADDR),
      .CFG_PATTERN (CFG_PATTERN),
      .CFG_REPEAT  (CFG_REPEAT),
      .NUM_SLOTS   (NUM_SLOTS),
      .LOOP        (LOOP),
      .START       (START),
      .ABORT       (ABORT),
      .GEN_LOAD    (GEN_LOAD),
      .GEN_VALUE   (GEN_VALUE),
      .SLOT_IDX    (SLOT_IDX),
      .BUSY        (BUSY),
      .DONE        (DONE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Generator model: load on strobe, otherwise rotate left; output is MSB.
   logic [15:0] gen_m = 16'h0000;
   always @(posedge CLK) begin
      gen_m <= GEN_LOAD ? GEN_VALUE : {gen_m[14:0], gen_m[15]};
   end

   int n_chk  = 0;
   int n_fail = 0;

   int          ld_pos [$];
   logic [15:0] ld_val [$];
   int          ld_idx [$];
   int          dn_pos [$];
   logic        dn_busy[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] p, input logic [3:0] r);
      CFG_WE = 1'b1; CFG_ADDR = a; CFG_PATTERN = p; CFG_REPEAT = r;
      step();
      CFG_WE = 1'b0;
   endtask

   task automatic start();
      START = 1'b1;
      step();
      START = 1'b0;
   endtask

   // Samples n+1 points: the current one, then after each of n edges.
   task automatic capture(input int n);
      ld_pos.delete(); ld_val.delete(); ld_idx.delete();
      dn_pos.delete(); dn_busy.delete();
      for (int j = 0; j <= n; j++) begin
         if (GEN_LOAD && BUSY) begin
            ld_pos.push_back(j);
            ld_val.push_back(GEN_VALUE);
            ld_idx.push_back(int'(SLOT_IDX));
         end
         if (DONE) begin
            dn_pos.push_back(j);
            dn_busy.push_back(BUSY);
         end
         if (j < n) step();
      end
   endtask

   task automatic chk_ld(input string tag, input int i, input int pos,
                         input logic [15:0] val, input int idx);
      if (i < ld_pos.size()) begin
         chk({tag, "_pos"}, ld_pos[i], pos);
         chk({tag, "_val"}, ld_val[i], val);
         chk({tag, "_idx"}, ld_idx[i], idx);
      end else begin
         chk({tag, "_missing"}, ld_pos.size(), i + 1);
      end
   endtask

   task automatic chk_done_at(input string tag, input int pos);
      chk({tag, "_ndone"}, dn_pos.size(), 1);
      if (dn_pos.size() == 1) begin
         chk({tag, "_done_pos"}, dn_pos[0], pos);
         chk({tag, "_done_busy"}, dn_busy[0], 1'b0);
      end
   endtask

   logic [17:0] bits_obs;
   logic [17:0] done_obs;

   initial begin
      RST_N = 1'b0; CFG_WE = 1'b0; CFG_ADDR = '0; CFG_PATTERN = '0; CFG_REPEAT = '0;
      NUM_SLOTS = 3'd1; LOOP = 1'b0; START = 1'b0; ABORT = 1'b0;

      // Reset values
      #12;
      chk("rst_load",  GEN_LOAD,  1'b1);
      chk("rst_value", GEN_VALUE, 16'h0000);
      chk("rst_idx",   SLOT_IDX,  2'd0);
      chk("rst_busy",  BUSY,      1'b0);
      chk("rst_done",  DONE,      1'b0);
      #2 RST_N = 1'b1;
      step();

      // 1: single slot, R=1, generator bit stream and DONE timing
      wr(2'd0, 16'h8001, 4'd1);
      NUM_SLOTS = 3'd1; LOOP = 1'b0;
      start();
      chk("t1_load",  GEN_LOAD,  1'b1);
      chk("t1_value", GEN_VALUE, 16'h8001);
      chk("t1_busy",  BUSY,      1'b1);
      bits_obs = '0; done_obs = '0;
      for (int j = 1; j <= 17; j++) begin
         step();
         bits_obs[j] = gen_m[15];
         done_obs[j] = DONE;
         if (j == 1)  chk("t1_run_load", GEN_LOAD, 1'b0);
         if (j == 16) begin
            chk("t1_end_busy",  BUSY,      1'b0);
            chk("t1_end_load",  GEN_LOAD,  1'b1);
            chk("t1_end_value", GEN_VALUE, 16'h0000);
         end
      end
      chk("t1_gen_bits", bits_obs, 18'h10002);
      chk("t1_done_vec", done_obs, 18'h10000);

      // 2: three slots with mixed repeats
      wr(2'd0, 16'hF000, 4'd2);
      wr(2'd1, 16'h00FF, 4'd1);
      wr(2'd2, 16'hAAAA, 4'd3);
      NUM_SLOTS = 3'd3;
      start();
      capture(100);
      chk("t2_nload", ld_pos.size(), 3);
      chk_ld("t2_ld0", 0, 0,  16'hF000, 0);
      chk_ld("t2_ld1", 1, 32, 16'h00FF, 1);
      chk_ld("t2_ld2", 2, 48, 16'hAAAA, 2);
      chk_done_at("t2", 96);

      // 3: looping single slot, then drop LOOP
      wr(2'd0, 16'h0001, 4'd1);
      NUM_SLOTS = 3'd1; LOOP = 1'b1;
      start();
      capture(64);
      chk("t3_nload", ld_pos.size(), 5);
      chk_ld("t3_ld3", 3, 48, 16'h0001, 0);
      chk_ld("t3_ld4", 4, 64, 16'h0001, 0);
      chk("t3_nodone", dn_pos.size(), 0);
      LOOP = 1'b0;
      capture(20);
      chk("t3_tail_nload", ld_pos.size(), 1);
      chk_done_at("t3", 16);

      // 4: mid-RUN abort, then START together with ABORT
      start();
      for (int j = 0; j < 7; j++) step();
      chk("t4_busy_pre", BUSY, 1'b1);
      ABORT = 1'b1;
      step();
      ABORT = 1'b0;
      chk("t4_load",  GEN_LOAD,  1'b1);
      chk("t4_value", GEN_VALUE, 16'h0000);
      chk("t4_busy",  BUSY,      1'b0);
      chk("t4_done",  DONE,      1'b0);
      capture(30);
      chk("t4_nodone", dn_pos.size(), 0);
      START = 1'b1; ABORT = 1'b1;
      step();
      START = 1'b0; ABORT = 1'b0;
      chk("t4b_busy",  BUSY,      1'b0);
      chk("t4b_value", GEN_VALUE, 16'h0000);
      capture(20);
      chk("t4b_nload", ld_pos.size(), 0);
      chk("t4b_ndone", dn_pos.size(), 0);

      // 5: repeat 0 -> 16 cycles; NUM_SLOTS 0 -> one slot; 7 -> clamp to 4
      wr(2'd0, 16'h3C3C, 4'd0);
      NUM_SLOTS = 3'd1;
      start();
      capture(20);
      chk("t5a_nload", ld_pos.size(), 1);
      chk_done_at("t5a", 16);
      NUM_SLOTS = 3'd0;
      start();
      capture(20);
      chk("t5b_nload", ld_pos.size(), 1);
      chk_done_at("t5b", 16);
      wr(2'd0, 16'h1111, 4'd1);
      wr(2'd1, 16'h2222, 4'd1);
      wr(2'd2, 16'h3333, 4'd1);
      wr(2'd3, 16'h4444, 4'd1);
      NUM_SLOTS = 3'd7;
      start();
      capture(70);
      chk("t5c_nload", ld_pos.size(), 4);
      chk_ld("t5c_ld0", 0, 0,  16'h1111, 0);
      chk_ld("t5c_ld3", 3, 48, 16'h4444, 3);
      chk_done_at("t5c", 64);

      // 6: write collides with slot-1 load; async reset mid-RUN clears table
      wr(2'd0, 16'h0F0F, 4'd1);
      wr(2'd1, 16'h5555, 4'd1);
      NUM_SLOTS = 3'd2;
      start();
      for (int j = 0; j < 15; j++) step();
      CFG_WE = 1'b1; CFG_ADDR = 2'd1; CFG_PATTERN = 16'h1234; CFG_REPEAT = 4'd1;
      step();
      CFG_WE = 1'b0;
      chk("t6_coll_load",  GEN_LOAD,  1'b1);
      chk("t6_coll_value", GEN_VALUE, 16'h5555);
      chk("t6_coll_idx",   SLOT_IDX,  2'd1);
      for (int j = 0; j < 4; j++) step();
      RST_N = 1'b0;
      #1;
      chk("t6_arst_load",  GEN_LOAD,  1'b1);
      chk("t6_arst_value", GEN_VALUE, 16'h0000);
      chk("t6_arst_idx",   SLOT_IDX,  2'd0);
      chk("t6_arst_busy",  BUSY,      1'b0);
      chk("t6_arst_done",  DONE,      1'b0);
      #2 RST_N = 1'b1;
      step();
      NUM_SLOTS = 3'd2;
      start();
      capture(40);
      chk("t6_nload", ld_pos.size(), 2);
      chk_ld("t6_ld0", 0, 0,  16'h0000, 0);
      chk_ld("t6_ld1", 1, 16, 16'h0000, 1);
      chk_done_at("t6", 32);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
